fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned fetch at a time to
// instruction memory, buffers responses in a 2-entry {pc, inst} FIFO for the
// decoder, and handles redirects by flushing the FIFO and discarding any
// response still in flight.
module fetch_unit #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h00000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h00000013);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [ADDR_WIDTH-1:0] fifo_pc_q [2];
  logic [INST_WIDTH-1:0] fifo_inst_q [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  outstanding_q, outstanding_d;
  logic                  drop_q, drop_d;

  logic accept;
  logic rsp;
  logic push;
  logic pop;

  // A new request is only allowed when its response is guaranteed a FIFO slot.
  assign imem_req_o  = !rst_i && !outstanding_q && !redirect_i &&
                       (({1'b0, count_q} + {2'b00, outstanding_q}) < 3'd2);
  assign imem_addr_o = pc_q;

  assign accept = imem_req_o & imem_gnt_i;
  assign rsp    = imem_rvalid_i & outstanding_q;
  assign push   = rsp & !drop_q;
  assign pop    = inst_valid_o & inst_ready_i;

  assign inst_valid_o = (count_q != 2'd0);
  assign inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : NOP;
  assign pc_o         = inst_valid_o ? fifo_pc_q[rd_ptr_q] : '0;

  // Next-state: normal fetch/push/pop bookkeeping, then redirect overrides.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (accept) begin
      pc_d          = pc_q + ADDR_WIDTH'(4);
      rsp_pc_d      = pc_q;
      outstanding_d = 1'b1;
    end
    if (rsp) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (redirect_i) begin
      pc_d     = redirect_pc_i & ~ADDR_WIDTH'(3);
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      // A response landing this very cycle retires the request, so only a
      // request that stays in flight needs its future response dropped.
      if (outstanding_q && !rsp) drop_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // FIFO storage; no reset needed since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push && !redirect_i && !rst_i) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: each task drives one scenario cycle by
// cycle and checks outputs against hand-computed values.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .pc_o          (pc)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving this cycle's inputs.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    tick();
    settle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_checks++; if (inst !== 32'h00000013) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000013", inst); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    tick();
    rst = 1'b0; imem_gnt = 1'b0;
    settle();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_streaming();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    settle();
    // C0: accept pc 0
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0007b2b7; settle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_req_busy: got %b expected 0", imem_req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b expected 0", inst_valid); end
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid0: got %b expected 1", inst_valid); end
    n_checks++; if (inst !== 32'h0007b2b7) begin n_fail++; $display("FAIL stream_inst0: got %h expected 0007b2b7", inst); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL stream_pc0: got %h expected 00000000", pc); end
    n_checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req4: got req %b addr %h expected req 1 addr 00000004", imem_req, imem_addr); end
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0007b297; settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap: got %b expected 0", inst_valid); end
    tick(); imem_rvalid = 1'b0; imem_gnt = 1'b0; settle();
    n_checks++; if (inst !== 32'h0007b297 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_inst1: got valid %b inst %h expected 1 0007b297", inst_valid, inst); end
    n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL stream_pc1: got %h expected 00000004", pc); end
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stream_addr8: got %h expected 00000008", imem_addr); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    settle();
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h11111111; settle();
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL bp_req4: got req %b addr %h expected 1 00000004", imem_req, imem_addr); end
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h22222222; settle();
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b expected 0", imem_req); end
    n_checks++; if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h11111111) begin n_fail++; $display("FAIL bp_head: got valid %b pc %h inst %h expected 1 00000000 11111111", inst_valid, pc, inst); end
    tick(); settle();
    n_checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || inst !== 32'h11111111) begin n_fail++; $display("FAIL bp_hold: got req %b pc %h inst %h expected 0 00000000 11111111", imem_req, pc, inst); end
    inst_ready = 1'b1; imem_gnt = 1'b0;
    tick(); inst_ready = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b1 || pc !== 32'h4 || inst !== 32'h22222222) begin n_fail++; $display("FAIL bp_pop: got valid %b pc %h inst %h expected 1 00000004 22222222", inst_valid, pc, inst); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_rereq: got req %b addr %h expected 1 00000008", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_grant_stall();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    settle();
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0000a001; settle();
    tick(); imem_rvalid = 1'b0; settle();
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0000a002; settle();
    tick(); imem_rvalid = 1'b0; imem_gnt = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_hold%0d: got req %b addr %h expected 1 00000008", i, imem_req, imem_addr); end
      tick(); settle();
    end
    imem_gnt = 1'b1; settle();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_grant: got req %b addr %h expected 1 00000008", imem_req, imem_addr); end
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000a003; settle();
    n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_advance: got %h expected 0000000c", imem_addr); end
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b1 || pc !== 32'h8 || inst !== 32'h0000a003) begin n_fail++; $display("FAIL stall_data: got valid %b pc %h inst %h expected 1 00000008 0000a003", inst_valid, pc, inst); end
    tick();
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    settle();
    tick(); redirect = 1'b1; redirect_pc = 32'h000004D3; settle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b expected 0", imem_req); end
    tick(); redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hdeadbeef; settle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_still_busy: got %b expected 0", imem_req); end
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_dropped: got %b expected 0", inst_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h000004D0) begin n_fail++; $display("FAIL redir_target: got req %b addr %h expected 1 000004d0", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00500513; settle();
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b1 || pc !== 32'h000004D0 || inst !== 32'h00500513) begin n_fail++; $display("FAIL redir_resume: got valid %b pc %h inst %h expected 1 000004d0 00500513", inst_valid, pc, inst); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    settle();
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h33333333; settle();
    tick(); imem_rvalid = 1'b0; settle();
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h44444444; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h00000100; settle();
    n_checks++; if (inst_valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL simul_pre: got valid %b pc %h expected 1 00000000", inst_valid, pc); end
    tick(); imem_rvalid = 1'b0; redirect = 1'b0; inst_ready = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h00000013 || pc !== 32'h0) begin n_fail++; $display("FAIL simul_flush: got valid %b inst %h pc %h expected 0 00000013 00000000", inst_valid, inst, pc); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h00000100) begin n_fail++; $display("FAIL simul_target: got req %b addr %h expected 1 00000100", imem_req, imem_addr); end
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h55555555; settle();
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b1 || pc !== 32'h00000100 || inst !== 32'h55555555) begin n_fail++; $display("FAIL simul_nodrop: got valid %b pc %h inst %h expected 1 00000100 55555555", inst_valid, pc, inst); end
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    settle();
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h66666666; settle();
    tick(); imem_rvalid = 1'b0; settle();
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h77777777; settle();
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_full: got valid %b req %b expected 1 0", inst_valid, imem_req); end
    rst = 1'b1; settle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_in_reset: got %b expected 0", imem_req); end
    tick(); settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_in_reset: got %b expected 0", inst_valid); end
    tick(); rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h88888888; settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_after: got %b expected 0", inst_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart: got req %b addr %h expected 1 00000000", imem_req, imem_addr); end
    tick(); imem_rvalid = 1'b0; settle();
    n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_stray_rvalid: got valid %b req %b expected 0 1", inst_valid, imem_req); end
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_grant_stall();
    test_redirect_outstanding();
    test_simultaneous();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
